// File: rtl/parity_frame_tx_if.sv
// parity_frame_tx_if -- word-in / serial-out bus for parity_frame_tx.
//   data_in    : word to transmit (master -> slave)
//   valid_in   : transmit request (master -> slave)
//   ready_out  : slave can accept a word
//   tx_out     : registered serial line, idle high
//   tx_busy    : frame in progress (~ready_out)
//   parity_out : parity of the most recently accepted word
//   done       : one-cycle frame-complete pulse
interface parity_frame_tx_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             ready_out;
    logic             tx_out;
    logic             tx_busy;
    logic             parity_out;
    logic             done;

    modport master (
        output data_in, valid_in,
        input  ready_out, tx_out, tx_busy, parity_out, done
    );

    modport slave (
        input  data_in, valid_in,
        output ready_out, tx_out, tx_busy, parity_out, done
    );
endinterface

// File: rtl/parity_frame_tx.sv
// parity_frame_tx -- serialises one WIDTH-bit word per frame:
//   start(0), D0..D(WIDTH-1) LSB first, parity, stop(1); each bit held
//   CLKS_PER_BIT clocks. ODD=0 gives even parity, ODD=1 odd parity.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : parity_frame_tx_if slave (data_in/valid_in in; ready_out,
//           tx_out, tx_busy, parity_out, done out)
module parity_frame_tx #(
    parameter int WIDTH        = 32,
    parameter int ODD          = 0,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                clock,
    input  logic                reset,
    parity_frame_tx_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [7:0]       CNT_LAST = 8'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic             ODD_BIT  = (ODD != 0);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [7:0]       cnt;
    logic [IDX_W-1:0] idx;
    logic             tx_r;
    logic             ready_r;
    logic             done_r;
    logic             par_r;
    logic             bit_end;

    assign bit_end = (cnt == CNT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            cnt     <= '0;
            idx     <= '0;
            tx_r    <= 1'b1;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
            par_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;

            // Bit-period counter: free-running modulo-C while a frame is out.
            if (state != IDLE) begin
                cnt <= bit_end ? '0 : cnt + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (bus.valid_in) begin
                        shreg   <= bus.data_in;
                        par_r   <= (^bus.data_in) ^ ODD_BIT;
                        tx_r    <= 1'b0;
                        ready_r <= 1'b0;
                        cnt     <= '0;
                        state   <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        tx_r  <= shreg[0];
                        shreg <= shreg >> 1;
                        idx   <= '0;
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (idx == IDX_LAST) begin
                            tx_r  <= par_r;
                            state <= PARITY;
                        end else begin
                            tx_r  <= shreg[0];
                            shreg <= shreg >> 1;
                            idx   <= idx + 1'b1;
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        tx_r  <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        ready_r <= 1'b1;
                        done_r  <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx_r    <= 1'b1;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.tx_out     = tx_r;
    assign bus.ready_out  = ready_r;
    assign bus.tx_busy    = ~ready_r;
    assign bus.done       = done_r;
    assign bus.parity_out = par_r;

endmodule

// File: tb/tb_parity_frame_tx.sv
// tb_parity_frame_tx -- directed bench for parity_frame_tx with three
// instances: u0 (C=1, even), u1 (C=1, odd), u2 (C=4, even). Expected
// per-cycle line state is queued at acceptance and popped each cycle.
module tb_parity_frame_tx;

    logic clock;
    logic reset;

    int n_pass  = 0;
    int n_total = 0;

    // {tx_out, ready_out, done} expected after each edge of a frame
    logic [2:0] exp_q[$];

    parity_frame_tx_if #(.WIDTH(32)) i0 ();
    parity_frame_tx_if #(.WIDTH(32)) i1 ();
    parity_frame_tx_if #(.WIDTH(32)) i2 ();

    parity_frame_tx #(.WIDTH(32), .ODD(0), .CLKS_PER_BIT(1)) u0 (
        .clock(clock), .reset(reset), .bus(i0.slave));
    parity_frame_tx #(.WIDTH(32), .ODD(1), .CLKS_PER_BIT(1)) u1 (
        .clock(clock), .reset(reset), .bus(i1.slave));
    parity_frame_tx #(.WIDTH(32), .ODD(0), .CLKS_PER_BIT(4)) u2 (
        .clock(clock), .reset(reset), .bus(i2.slave));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    endtask

    // {tx_out, ready_out, tx_busy, done, parity_out}
    function automatic logic [4:0] outs(input int sel);
        case (sel)
            0:       return {i0.tx_out, i0.ready_out, i0.tx_busy, i0.done, i0.parity_out};
            1:       return {i1.tx_out, i1.ready_out, i1.tx_busy, i1.done, i1.parity_out};
            default: return {i2.tx_out, i2.ready_out, i2.tx_busy, i2.done, i2.parity_out};
        endcase
    endfunction

    task automatic set_in(input int sel, input logic [31:0] d, input logic v);
        case (sel)
            0:       begin i0.data_in = d; i0.valid_in = v; end
            1:       begin i1.data_in = d; i1.valid_in = v; end
            default: begin i2.data_in = d; i2.valid_in = v; end
        endcase
    endtask

    task automatic chk_reset_state(input string tag, input int sel);
        logic [4:0] o;
        o = outs(sel);
        chk({tag, "_tx"},     32'(o[4]), 32'd1);
        chk({tag, "_ready"},  32'(o[3]), 32'd1);
        chk({tag, "_busy"},   32'(o[2]), 32'd0);
        chk({tag, "_done"},   32'(o[1]), 32'd0);
        chk({tag, "_parity"}, 32'(o[0]), 32'd0);
    endtask

    // Sends one word and checks the line every cycle through done.
    // pre_driven: valid/data already presented at a ready cycle.
    // hold: keep valid high and switch data_in to next_word mid-frame.
    // abort_at: stop checking after sample j (-1 = full frame).
    task automatic frame(input int sel, input logic [31:0] word, input int c,
                         input bit odd, input bit pre_driven, input bit hold,
                         input logic [31:0] next_word, input int abort_at);
        logic       p;
        logic       b;
        int         n;
        logic [2:0] e;
        logic [4:0] o;
        if (!pre_driven) begin
            @(negedge clock);
            o = outs(sel);
            chk("ready_before_accept", 32'(o[3]), 32'd1);
            set_in(sel, word, 1'b1);
        end
        @(posedge clock);
        p = (^word) ^ odd;
        n = c * 35;
        for (int j = 0; j < n; j++) begin
            if (j < c)            b = 1'b0;
            else if (j < c * 33)  b = word[(j / c) - 1];
            else if (j < c * 34)  b = p;
            else                  b = 1'b1;
            exp_q.push_back({b, 1'b0, 1'b0});
        end
        exp_q.push_back(3'b111);
        for (int j = 0; j <= n; j++) begin
            @(negedge clock);
            if (j == 0) begin
                if (hold) set_in(sel, next_word, 1'b1);
                else      set_in(sel, ~word, 1'b0);
            end
            e = exp_q.pop_front();
            o = outs(sel);
            chk($sformatf("tx_s%0d_j%0d", sel, j),    32'(o[4]), 32'(e[2]));
            chk($sformatf("ready_s%0d_j%0d", sel, j), 32'(o[3]), 32'(e[1]));
            chk($sformatf("busy_s%0d_j%0d", sel, j),  32'(o[2]), 32'(!e[1]));
            chk($sformatf("done_s%0d_j%0d", sel, j),  32'(o[1]), 32'(e[0]));
            chk($sformatf("par_s%0d_j%0d", sel, j),   32'(o[0]), 32'(p));
            if (j == abort_at) begin
                exp_q.delete();
                return;
            end
        end
    endtask

    initial begin
        logic [4:0] o;
        reset = 1'b0;
        set_in(0, '0, 1'b0);
        set_in(1, '0, 1'b0);
        set_in(2, '0, 1'b0);

        // Asynchronous reset between edges
        #1 reset = 1'b1;
        #1;
        chk_reset_state("rst0_u0", 0);
        chk_reset_state("rst0_u1", 1);
        chk_reset_state("rst0_u2", 2);
        @(negedge clock);
        reset = 1'b0;

        // Even parity, 45 -> 1,0,1,1,0,1 then zeros, P=0
        frame(0, 32'd45, 1, 1'b0, 1'b0, 1'b0, '0, -1);
        // Odd parity, all ones -> P=1
        frame(1, 32'hFFFF_FFFF, 1, 1'b1, 1'b0, 1'b0, '0, -1);
        // Four clocks per bit
        frame(2, 32'h8000_0001, 4, 1'b0, 1'b0, 1'b0, '0, -1);

        // valid held, data changed mid-frame; next word accepted after one idle cycle
        frame(0, 32'd45, 1, 1'b0, 1'b0, 1'b1, 32'h1234_5678, -1);
        frame(0, 32'h1234_5678, 1, 1'b0, 1'b1, 1'b0, '0, -1);
        o = outs(0);
        chk("parity_hold_after_frame", 32'(o[0]), 32'(^32'h1234_5678));

        // Reset during data bit 10 (u0 parity_out currently 1)
        frame(0, 32'hFFFF_F7FF, 1, 1'b0, 1'b0, 1'b0, '0, 11);
        #2 reset = 1'b1;
        #1;
        chk_reset_state("rst_mid_u0", 0);
        @(posedge clock);
        @(negedge clock);
        chk_reset_state("rst_held_u0", 0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            o = outs(0);
            chk($sformatf("no_done_after_abort_%0d", k), 32'(o[1]), 32'd0);
        end
        frame(0, 32'd45, 1, 1'b0, 1'b0, 1'b0, '0, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
